mem_bridge: RTL and testbench

- Sits directly downstream of the multicycle CPU core, on its unified instruction/data memory port.
- Consumes Gmem_R/Gmem_W, GmemAddr, dataOut and MEM_S/MEM_C, and drives a word-wide synchronous RAM.
- Returns the formatted dataIn word plus a completion strobe.
- Handles byte/halfword extract with sign/zero extension, read-modify-write for sub-word stores, alignment checking, and a configurable RAM read latency.

---
 rtl/mem_bridge_pkg.sv | 33 +++
 rtl/mem_bridge_lane_fmt.sv | 62 ++++++
 rtl/mem_bridge.sv | 154 +++++++++++++++
 tb/tb_mem_bridge.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the CPU-to-RAM memory bridge: size codes, FSM states,
// read-latency bound and request validity check.
// Optional feature macro: MEM_BRIDGE_WSTRB_EN (byte-strobe stores, no RMW).
package mem_bridge_pkg;

    localparam int RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR,
        DONE,
        ERR
    } state_e;

    // A request is rejected when it is misaligned, uses the reserved size,
    // or asks for read and write at the same time.
    function automatic logic req_bad(input logic rd, input logic wr,
                                     input logic [1:0] size, input logic [1:0] lane);
        return (rd && wr) || (size == SZ_RSVD) ||
               (size == SZ_HALF && lane[0]) ||
               (size == SZ_WORD && lane != 2'b00);
    endfunction

endpackage

// File: rtl/mem_bridge_lane_fmt.sv
// Lane formatter: load extract/extend and store merge/replicate. Purely
// combinational, no state.
// Optional feature macro: MEM_BRIDGE_WSTRB_EN (direct sub-word stores use
// replicated data and lane strobes instead of a merged word).
module mem_lane_fmt
    import mem_bridge_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  size_e       size,
    input  logic        sign,
    input  logic [1:0]  lane,
    input  logic        merge,
    output logic [31:0] load_data,
    output logic [31:0] store_data,
    output logic [3:0]  store_be
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

    // Load formatting plus either the RMW merged word or the direct store word
    always_comb begin
        load_data  = rdata;
        store_data = wdata;
        store_be   = 4'hF;
        case (size)
            SZ_BYTE: load_data = {{24{sign & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{sign & half_sel[15]}}, half_sel};
            default: ;
        endcase
        if (merge) begin
            store_data = rdata;
            case (size)
                SZ_BYTE: store_data[{lane, 3'b000} +: 8] = wdata[7:0];
                SZ_HALF: begin
                    if (lane[1]) store_data[31:16] = wdata[15:0];
                    else         store_data[15:0]  = wdata[15:0];
                end
                default: store_data = wdata;
            endcase
        end else begin
`ifdef MEM_BRIDGE_WSTRB_EN
            case (size)
                SZ_BYTE: begin
                    store_data = {4{wdata[7:0]}};
                    store_be   = 4'b0001 << lane;
                end
                SZ_HALF: begin
                    store_data = {2{wdata[15:0]}};
                    store_be   = lane[1] ? 4'b1100 : 4'b0011;
                end
                default: ;
            endcase
`endif
        end
    end

endmodule

// File: rtl/mem_bridge.sv
// Memory bridge between the multicycle CPU memory port and a word-wide
// synchronous RAM: sub-word loads/stores, alignment checks, RD_LAT read latency.
// Optional feature macro: MEM_BRIDGE_WSTRB_EN (sub-word stores use byte
// strobes and skip the read-modify-write).
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Gmem_R,
    input  logic              Gmem_W,
    input  logic [31:0]       GmemAddr,
    input  logic [31:0]       dataOut,
    input  logic              MEM_S,
    input  logic [1:0]        MEM_C,
    output logic [31:0]       dataIn,
    output logic              mem_ready,
    output logic              addr_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    // Last RD_WAIT count; RD_LAT is bounded by RD_LAT_MAX so it fits 2 bits.
    localparam logic [1:0] LAST = 2'(RD_LAT - 1);

    state_e            state;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        lane_q;
    size_e             size_q;
    logic              sign_q;
    logic              wr_q;
    logic [31:0]       wdata_q;

    logic              in_idle;
    logic              bad;
    logic              direct_wr;
    logic [31:0]       load_data;
    logic [31:0]       store_data;
    logic [3:0]        store_be;
    logic              unused_addr;

    assign in_idle     = (state == IDLE);
    assign bad         = req_bad(Gmem_R, Gmem_W, MEM_C, GmemAddr[1:0]);
    assign ram_addr    = addr_q;
    assign unused_addr = ^GmemAddr[31:ADDR_W+2];

`ifdef MEM_BRIDGE_WSTRB_EN
    assign direct_wr = 1'b1;
`else
    assign direct_wr = (MEM_C == SZ_WORD);
`endif

    // In IDLE the formatter sees the live request (direct store path); in
    // every other state it works on latched fields and the RAM read word.
    mem_lane_fmt u_fmt (
        .rdata      (ram_rdata),
        .wdata      (in_idle ? dataOut : wdata_q),
        .size       (in_idle ? size_e'(MEM_C) : size_q),
        .sign       (sign_q),
        .lane       (in_idle ? GmemAddr[1:0] : lane_q),
        .merge      (!in_idle),
        .load_data  (load_data),
        .store_data (store_data),
        .store_be   (store_be)
    );

    // Request FSM with registered RAM controls and CPU response
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            lane_q    <= '0;
            size_q    <= SZ_WORD;
            sign_q    <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            dataIn    <= '0;
            mem_ready <= 1'b0;
            addr_err  <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_be    <= 4'hF;
            ram_wdata <= '0;
        end else begin
            mem_ready <= 1'b0;
            addr_err  <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (Gmem_R || Gmem_W) begin
                        addr_q  <= GmemAddr[ADDR_W+1:2];
                        lane_q  <= GmemAddr[1:0];
                        size_q  <= size_e'(MEM_C);
                        sign_q  <= MEM_S;
                        wr_q    <= Gmem_W;
                        wdata_q <= dataOut;
                        if (bad) begin
                            state     <= ERR;
                            mem_ready <= 1'b1;
                            addr_err  <= 1'b1;
                            dataIn    <= '0;
                        end else if (Gmem_W && direct_wr) begin
                            state     <= WR;
                            ram_we    <= 1'b1;
                            ram_wdata <= store_data;
                            ram_be    <= store_be;
                        end else begin
                            state  <= RD_ISSUE;
                            ram_en <= 1'b1;
                        end
                    end
                end
                RD_ISSUE: begin
                    state <= RD_WAIT;
                    cnt   <= '0;
                end
                RD_WAIT: begin
                    if (cnt == LAST) begin
                        if (wr_q) begin
                            state     <= WR;
                            ram_we    <= 1'b1;
                            ram_wdata <= store_data;
                            ram_be    <= store_be;
                        end else begin
                            state     <= DONE;
                            mem_ready <= 1'b1;
                            dataIn    <= load_data;
                        end
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                WR: begin
                    state     <= DONE;
                    mem_ready <= 1'b1;
                    ram_be    <= 4'hF;
                end
                DONE, ERR: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: two instances (RD_LAT=1 and RD_LAT=3), each
// with its own behavioural RAM. Expectations are pushed when a request is
// driven and popped when the bridge signals completion.
module tb_mem_bridge;
    import mem_bridge_pkg::*;

    localparam int AW = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          g_r [2];
    logic          g_w [2];
    logic          g_s [2];
    logic [31:0]   g_a [2];
    logic [31:0]   g_d [2];
    logic [1:0]    g_c [2];
    logic [31:0]   d_in [2];
    logic          rdy [2];
    logic          aerr [2];
    logic          r_en [2];
    logic          r_we [2];
    logic [3:0]    r_be [2];
    logic [AW-1:0] r_addr [2];
    logic [31:0]   r_wd [2];
    logic [31:0]   r_rd [2];

    logic [31:0]   mem  [2][2**AW];
    logic [31:0]   pipe [2][3];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_bridge #(.ADDR_W(AW), .RD_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst(rst),
            .Gmem_R(g_r[g]), .Gmem_W(g_w[g]), .GmemAddr(g_a[g]), .dataOut(g_d[g]),
            .MEM_S(g_s[g]), .MEM_C(g_c[g]),
            .dataIn(d_in[g]), .mem_ready(rdy[g]), .addr_err(aerr[g]),
            .ram_en(r_en[g]), .ram_we(r_we[g]), .ram_be(r_be[g]),
            .ram_addr(r_addr[g]), .ram_wdata(r_wd[g]), .ram_rdata(r_rd[g])
        );
    end

    assign r_rd[0] = pipe[0][0];
    assign r_rd[1] = pipe[1][2];

    // Behavioural RAM: read pipeline of RD_LAT stages, byte-enabled writes
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            pipe[g][0] <= r_en[g] ? mem[g][r_addr[g]] : 32'hDEADBEEF;
            pipe[g][1] <= pipe[g][0];
            pipe[g][2] <= pipe[g][1];
            if (r_we[g])
                for (int b = 0; b < 4; b++)
                    if (r_be[g][b]) mem[g][r_addr[g]][8*b +: 8] = r_wd[g][8*b +: 8];
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic        err;
        int          lat;
        int          en;
        int          we;
        int          we_cyc;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        chk_wd;
        logic [31:0] waddr;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic rst_chk(input int id, input string tag);
        chk({tag, "/dataIn"},    d_in[id],          32'h0);
        chk({tag, "/mem_ready"}, 32'(rdy[id]),      32'h0);
        chk({tag, "/addr_err"},  32'(aerr[id]),     32'h0);
        chk({tag, "/ram_en"},    32'(r_en[id]),     32'h0);
        chk({tag, "/ram_we"},    32'(r_we[id]),     32'h0);
        chk({tag, "/ram_be"},    32'(r_be[id]),     32'hF);
        chk({tag, "/ram_addr"},  32'(r_addr[id]),   32'h0);
        chk({tag, "/ram_wdata"}, r_wd[id],          32'h0);
    endtask

    // One CPU access: push the modelled outcome, drive, wait for completion, compare
    task automatic op(input int id, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic s, input logic [1:0] c,
                      input logic [31:0] exp_d, input string tag);
        exp_t e;
        int   L = (id == 0) ? 1 : 3;
        logic bad, direct, got;
        int   n, en_cnt, we_cnt, we_cyc;
        logic [3:0]  we_be;
        logic [31:0] we_d;
        logic [31:0] en_a;
        bad = (rd && wr) || (c == 2'b11) || (c == 2'b01 && a[0]) || (c == 2'b00 && a[1:0] != 2'b00);
`ifdef MEM_BRIDGE_WSTRB_EN
        direct = wr;
`else
        direct = wr && (c == 2'b00);
`endif
        e.err      = bad;
        e.data     = bad ? 32'h0 : exp_d;
        e.chk_data = bad || !wr;
        e.lat      = bad ? 1 : direct ? 2 : wr ? L + 3 : L + 2;
        e.en       = (bad || direct) ? 0 : 1;
        e.we       = (!bad && wr) ? 1 : 0;
        e.we_cyc   = direct ? 1 : L + 2;
        e.be       = 4'hF;
        e.wd       = d;
        e.chk_wd   = direct;
        e.waddr    = {21'h0, a[12:2]};
        if (direct && c == 2'b10) begin e.be = 4'b0001 << a[1:0]; e.wd = {4{d[7:0]}}; end
        if (direct && c == 2'b01) begin e.be = a[1] ? 4'b1100 : 4'b0011; e.wd = {2{d[15:0]}}; end
        sb_q.push_back(e);

        @(negedge clk);
        g_r[id] = rd; g_w[id] = wr; g_a[id] = a; g_d[id] = d; g_s[id] = s; g_c[id] = c;
        n = 0; en_cnt = 0; we_cnt = 0; we_cyc = -1; got = 1'b0;
        we_be = 4'h0; we_d = 32'h0; en_a = 32'h0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (r_en[id]) begin en_cnt++; en_a = 32'(r_addr[id]); end
            if (r_we[id]) begin we_cnt++; we_cyc = n; we_be = r_be[id]; we_d = r_wd[id]; end
            if (rdy[id]) begin
                got = 1'b1;
                g_r[id] = 1'b0; g_w[id] = 1'b0;
            end
        end

        e = sb_q.pop_front();
        if (!got) begin
            g_r[id] = 1'b0; g_w[id] = 1'b0;
            chk({tag, "/timeout"}, 32'h0, 32'h1);
            return;
        end
        chk({tag, "/lat"},  32'(n),        32'(e.lat));
        chk({tag, "/err"},  32'(aerr[id]), 32'(e.err));
        if (e.chk_data) chk({tag, "/data"}, d_in[id], e.data);
        chk({tag, "/en_cnt"}, 32'(en_cnt), 32'(e.en));
        chk({tag, "/we_cnt"}, 32'(we_cnt), 32'(e.we));
        if (e.en == 1) chk({tag, "/en_addr"}, en_a, e.waddr);
        if (e.we == 1) begin
            chk({tag, "/we_cyc"}, 32'(we_cyc), 32'(e.we_cyc));
            chk({tag, "/be"},     32'(we_be),  32'(e.be));
            if (e.chk_wd) chk({tag, "/wdata"}, we_d, e.wd);
        end
    endtask

    initial begin
        int rdy_cnt, we_cnt;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            g_r[i] = 1'b0; g_w[i] = 1'b0; g_s[i] = 1'b0;
            g_a[i] = 32'h0; g_d[i] = 32'h0; g_c[i] = 2'b00;
        end
        for (int i = 0; i < 2**AW; i++) begin mem[0][i] = 32'h0; mem[1][i] = 32'h0; end
        mem[0][16] = 32'h8899AABB;
        mem[1][16] = 32'h8899AABB;
        repeat (3) @(negedge clk);
        rst_chk(0, "rst0");
        rst_chk(1, "rst1");
        rst = 1'b0;

        // RD_LAT=1 instance: loads with every lane/extension combination
        op(0, 1, 0, 32'h41, 32'h0, 1, SZ_BYTE, 32'hFFFFFFAA, "lb41");
        op(0, 1, 0, 32'h41, 32'h0, 0, SZ_BYTE, 32'h000000AA, "lbu41");
        op(0, 1, 0, 32'h42, 32'h0, 0, SZ_HALF, 32'h00008899, "lhu42");
        op(0, 1, 0, 32'h42, 32'h0, 1, SZ_HALF, 32'hFFFF8899, "lh42");
        op(0, 1, 0, 32'h40, 32'h0, 1, SZ_BYTE, 32'hFFFFFFBB, "lb40");
        op(0, 1, 0, 32'h40, 32'h0, 1, SZ_HALF, 32'hFFFFAABB, "lh40");
        op(0, 1, 0, 32'h40, 32'h0, 1, SZ_WORD, 32'h8899AABB, "lw40");

        // Sub-word stores
        op(0, 0, 1, 32'h43, 32'h12345677, 0, SZ_BYTE, 32'h0, "sb43");
        chk("sb43/ram", mem[0][16], 32'h7799AABB);
        op(0, 0, 1, 32'h42, 32'h0000CAFE, 0, SZ_HALF, 32'h0, "sh42");
        chk("sh42/ram", mem[0][16], 32'hCAFEAABB);
        op(0, 1, 0, 32'h43, 32'h0, 1, SZ_BYTE, 32'hFFFFFFCA, "lb43");

        // Rejected requests
        op(0, 1, 0, 32'h41, 32'h0, 1, SZ_HALF, 32'h0, "lh41err");
        op(0, 0, 1, 32'h42, 32'h1, 0, SZ_WORD, 32'h0, "sw42err");
        op(0, 1, 1, 32'h40, 32'h2, 0, SZ_WORD, 32'h0, "rwerr");
        op(0, 1, 0, 32'h40, 32'h0, 0, SZ_RSVD, 32'h0, "rsvd");
        chk("err/ram", mem[0][16], 32'hCAFEAABB);
        op(0, 1, 0, 32'h40, 32'h0, 0, SZ_WORD, 32'hCAFEAABB, "lw40b");

        // RD_LAT=3 instance: back-to-back word traffic and an RMW
        op(1, 1, 0, 32'h40, 32'h0, 0, SZ_WORD, 32'h8899AABB, "L3lw40");
        op(1, 0, 1, 32'h44, 32'h11223344, 0, SZ_WORD, 32'h0, "L3sw44");
        chk("L3sw44/ram", mem[1][17], 32'h11223344);
        op(1, 1, 0, 32'h44, 32'h0, 0, SZ_WORD, 32'h11223344, "L3lw44");
        op(1, 0, 1, 32'h41, 32'h000000C3, 0, SZ_BYTE, 32'h0, "L3sb41");
        chk("L3sb41/ram", mem[1][16], 32'h8899C3BB);
        op(1, 1, 0, 32'h40, 32'h0, 0, SZ_HALF, 32'h0000C3BB, "L3lhu40");

        // Reset while the access is in RD_WAIT
        @(negedge clk);
`ifdef MEM_BRIDGE_WSTRB_EN
        g_r[1] = 1'b1; g_w[1] = 1'b0;
`else
        g_r[1] = 1'b0; g_w[1] = 1'b1;
`endif
        g_a[1] = 32'h42; g_d[1] = 32'h000000EE; g_s[1] = 1'b0; g_c[1] = SZ_BYTE;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        g_r[1] = 1'b0; g_w[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rst_chk(1, "midrst");
        rdy_cnt = 0; we_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdy[1]) rdy_cnt++;
            if (r_we[1]) we_cnt++;
        end
        chk("midrst/ready_cnt", 32'(rdy_cnt), 32'h0);
        chk("midrst/we_cnt",    32'(we_cnt),  32'h0);
        chk("midrst/ram",       mem[1][16],   32'h8899C3BB);
        op(1, 1, 0, 32'h40, 32'h0, 0, SZ_WORD, 32'h8899C3BB, "L3lw40post");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
